// File: rtl/chimp_pkg.sv
// Shared definitions for the chimp game: cell-word layout, colours, mode code
// and the drawer state encoding.
package chimp_pkg;

  localparam int ACTIVE_BIT = 6;
  localparam int SHOW_BIT   = 5;
  localparam int NUM_MSB    = 4;

  localparam logic [2:0] BLACK = 3'b000;
  localparam logic [2:0] WHITE = 3'b111;
  localparam logic [2:0] BLUE  = 3'b001;

  localparam logic [1:0] GAME_CHIMP = 2'b10;

  localparam int TILE = 16;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FETCH = 3'd1,
    ST_LATCH = 3'd2,
    ST_DRAW  = 3'd3,
    ST_DONE  = 3'd4
  } drawer_state_t;

endpackage

// File: rtl/chimp_digit_font.sv
// 3x5 decimal digit font; returns one glyph bit. Out-of-range digit/row/col
// read as background.
module chimp_digit_font (
  input  logic [3:0] i_digit,
  input  logic [2:0] i_row,
  input  logic [1:0] i_col,
  output logic       o_pixel
);

  logic [14:0] w_bits;
  logic [3:0]  w_idx;

  // Rows packed top to bottom, three bits each, leftmost column in the MSB.
  always_comb begin
    case (i_digit)
      4'd0:    w_bits = 15'b111_101_101_101_111;
      4'd1:    w_bits = 15'b010_110_010_010_111;
      4'd2:    w_bits = 15'b111_001_111_100_111;
      4'd3:    w_bits = 15'b111_001_111_001_111;
      4'd4:    w_bits = 15'b101_101_111_001_001;
      4'd5:    w_bits = 15'b111_100_111_001_111;
      4'd6:    w_bits = 15'b111_100_111_101_111;
      4'd7:    w_bits = 15'b111_001_001_001_001;
      4'd8:    w_bits = 15'b111_101_111_101_111;
      4'd9:    w_bits = 15'b111_101_111_001_111;
      default: w_bits = 15'b0;
    endcase
  end

  assign w_idx = ({1'b0, i_row} * 4'd3) + {2'b00, i_col};

  always_comb begin
    o_pixel = 1'b0;
    if (i_row <= 3'd4 && i_col <= 2'd2)
      o_pixel = w_bits[4'd14 - w_idx];
  end

endmodule

// File: rtl/chimp_grid_drawer.sv
// Sweeps every chimp cell, fetches its status word and paints a 16x16 tile
// per cell, one pixel per cycle, into the VGA pixel-write port.
module chimp_grid_drawer
  import chimp_pkg::*;
#(
  parameter  int COLS   = 8,
  parameter  int ROWS   = 5,
  parameter  int X0     = 16,
  parameter  int Y0     = 20,
  localparam int NCELLS = COLS * ROWS,
  localparam int AW     = $clog2(NCELLS)
) (
  input  logic          clk,
  input  logic          iReset,
  input  logic [1:0]    iGameMode,
  input  logic          iStart,
  output logic [AW-1:0] oCellAddr,
  input  logic [6:0]    iCellData,
  output logic [7:0]    oX,
  output logic [6:0]    oY,
  output logic [2:0]    oColour,
  output logic          oPlot,
  output logic          oBusy,
  output logic          oDone
);

  localparam int CW = (COLS > 1) ? $clog2(COLS) : 1;
  localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;

  drawer_state_t r_state;
  logic [AW-1:0] r_cell;
  logic [CW-1:0] r_col;
  logic [RW-1:0] r_row;
  logic [3:0]    r_px;
  logic [3:0]    r_py;
  logic [6:0]    r_word;
  logic          r_plot;
  logic          r_busy;
  logic          r_done;

  logic [4:0] w_num;
  logic [3:0] w_tens;
  logic [4:0] w_tens_sub;
  logic [3:0] w_ones;
  logic       w_in_rows;
  logic       w_in_tens;
  logic       w_in_ones;
  logic [3:0] w_py_off;
  logic [3:0] w_px_off;
  logic [2:0] w_font_row;
  logic [1:0] w_font_col;
  logic [3:0] w_digit;
  logic       w_font_pix;
  logic       w_glyph;
  logic [2:0] w_colour;
  logic [7:0] w_x;
  logic [6:0] w_y;
  logic       w_abort;

  assign w_abort = (iGameMode != GAME_CHIMP);

  always_ff @(posedge clk or negedge iReset) begin
    if (!iReset) begin
      r_state <= ST_IDLE;
      r_cell  <= '0;
      r_col   <= '0;
      r_row   <= '0;
      r_px    <= '0;
      r_py    <= '0;
      r_word  <= '0;
      r_plot  <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (iStart && !w_abort) begin
            r_state <= ST_FETCH;
            r_cell  <= '0;
            r_col   <= '0;
            r_row   <= '0;
            r_busy  <= 1'b1;
          end
        end
        ST_DONE: r_state <= ST_IDLE;
        default: begin
          if (w_abort) begin
            r_state <= ST_IDLE;
            r_plot  <= 1'b0;
            r_busy  <= 1'b0;
          end else begin
            case (r_state)
              ST_FETCH: r_state <= ST_LATCH;
              ST_LATCH: begin
                r_word  <= iCellData;
                r_px    <= '0;
                r_py    <= '0;
                r_plot  <= 1'b1;
                r_state <= ST_DRAW;
              end
              ST_DRAW: begin
                r_px <= r_px + 4'd1;
                if (r_px == 4'd15) begin
                  r_py <= r_py + 4'd1;
                  if (r_py == 4'd15) begin
                    r_plot <= 1'b0;
                    if (r_cell == AW'(NCELLS - 1)) begin
                      r_state <= ST_DONE;
                      r_busy  <= 1'b0;
                      r_done  <= 1'b1;
                    end else begin
                      r_state <= ST_FETCH;
                      r_cell  <= r_cell + 1'b1;
                      // col/row track cell so pixel coordinates need no divider.
                      if (r_col == CW'(COLS - 1)) begin
                        r_col <= '0;
                        r_row <= r_row + 1'b1;
                      end else begin
                        r_col <= r_col + 1'b1;
                      end
                    end
                  end
                end
              end
              default: r_state <= ST_IDLE;
            endcase
          end
        end
      endcase
    end
  end

  assign w_num = r_word[NUM_MSB:0];

  always_comb begin
    w_tens     = 4'd0;
    w_tens_sub = 5'd0;
    if (w_num >= 5'd30) begin
      w_tens = 4'd3; w_tens_sub = 5'd30;
    end else if (w_num >= 5'd20) begin
      w_tens = 4'd2; w_tens_sub = 5'd20;
    end else if (w_num >= 5'd10) begin
      w_tens = 4'd1; w_tens_sub = 5'd10;
    end
  end

  assign w_ones     = 4'(w_num - w_tens_sub);
  assign w_in_rows  = (r_py >= 4'd3) && (r_py <= 4'd12);
  assign w_in_tens  = w_in_rows && (r_px >= 4'd1) && (r_px <= 4'd6) && (w_tens != 4'd0);
  assign w_in_ones  = w_in_rows && (r_px >= 4'd8) && (r_px <= 4'd13);
  assign w_py_off   = r_py - 4'd3;
  assign w_px_off   = w_in_tens ? (r_px - 4'd1) : (r_px - 4'd8);
  // Font is scaled x2, so drop the low offset bit in each direction.
  assign w_font_row = 3'(w_py_off >> 1);
  assign w_font_col = 2'(w_px_off >> 1);
  assign w_digit    = w_in_tens ? w_tens : w_ones;

  chimp_digit_font u_font (
    .i_digit (w_digit),
    .i_row   (w_font_row),
    .i_col   (w_font_col),
    .o_pixel (w_font_pix)
  );

  assign w_glyph = w_font_pix && (w_in_tens || w_in_ones);

  always_comb begin
    w_colour = BLACK;
    if (r_px == 4'd15 || r_py == 4'd15 || !r_word[ACTIVE_BIT])
      w_colour = BLACK;
    else if (!r_word[SHOW_BIT])
      w_colour = WHITE;
    else if (w_glyph)
      w_colour = WHITE;
    else
      w_colour = BLUE;
  end

  assign w_x = 8'(X0 + TILE * int'(r_col) + int'(r_px));
  assign w_y = 7'(Y0 + TILE * int'(r_row) + int'(r_py));

  assign oCellAddr = r_cell;
  assign oX        = r_plot ? w_x : 8'd0;
  assign oY        = r_plot ? w_y : 7'd0;
  assign oColour   = r_plot ? w_colour : 3'd0;
  assign oPlot     = r_plot;
  assign oBusy     = r_busy;
  assign oDone     = r_done;

endmodule

// File: tb/tb_chimp_grid_drawer.sv
// Directed bench for chimp_grid_drawer: full sweeps, tile colouring, glyphs,
// abort on mode change and asynchronous reset.
module tb_chimp_grid_drawer;

  logic       clk;
  logic       iReset;
  logic [1:0] iGameMode;
  logic       iStart;
  logic [5:0] oCellAddr;
  logic [6:0] iCellData;
  logic [7:0] oX;
  logic [6:0] oY;
  logic [2:0] oColour;
  logic       oPlot;
  logic       oBusy;
  logic       oDone;

  int n_cmp = 0;
  int n_bad = 0;

  logic [6:0]  mem   [0:39];
  logic [2:0]  frame [0:143][0:99];
  logic [14:0] font  [0:9];

  int s_plots, s_nonblack, s_done_cnt, s_done_cyc, s_busy1, s_busy_bad;
  int s_first_x, s_first_y, s_last_x, s_last_y;

  chimp_grid_drawer dut (
    .clk       (clk),
    .iReset    (iReset),
    .iGameMode (iGameMode),
    .iStart    (iStart),
    .oCellAddr (oCellAddr),
    .iCellData (iCellData),
    .oX        (oX),
    .oY        (oY),
    .oColour   (oColour),
    .oPlot     (oPlot),
    .oBusy     (oBusy),
    .oDone     (oDone)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // cell-word memory: data valid one cycle after the address
  always @(posedge clk) iCellData <= mem[oCellAddr];

  function automatic int font_bit(input int d, input int r, input int c);
    logic [14:0] f;
    f = font[d];
    return int'(f[14 - (r * 3 + c)]);
  endfunction

  // reference colour computed from screen coordinates
  function automatic int exp_colour(input int x, input int y);
    int tx, ty, px, py, n, tens, ones;
    logic [6:0] w;
    tx = (x - 16) / 16; ty = (y - 20) / 16;
    px = (x - 16) % 16; py = (y - 20) % 16;
    w  = mem[ty * 8 + tx];
    if (px == 15 || py == 15) return 0;
    if (!w[6]) return 0;
    if (!w[5]) return 7;
    n = int'(w[4:0]); tens = n / 10; ones = n % 10;
    if (py >= 3 && py <= 12) begin
      if (tens != 0 && px >= 1 && px <= 6 && font_bit(tens, (py - 3) / 2, (px - 1) / 2) == 1) return 7;
      if (px >= 8 && px <= 13 && font_bit(ones, (py - 3) / 2, (px - 8) / 2) == 1) return 7;
    end
    return 1;
  endfunction

  task automatic pulse_start();
    @(negedge clk); iStart = 1'b1;
    @(posedge clk);
    @(negedge clk); iStart = 1'b0;
  endtask

  task automatic run_sweep(input int limit);
    s_plots = 0; s_nonblack = 0; s_done_cnt = 0; s_done_cyc = -1;
    s_busy1 = 0; s_busy_bad = 0;
    s_first_x = -1; s_first_y = -1; s_last_x = -1; s_last_y = -1;
    for (int x = 0; x < 144; x++)
      for (int y = 0; y < 100; y++) frame[x][y] = 3'd0;
    pulse_start();
    for (int cyc = 1; cyc <= limit; cyc++) begin
      if (cyc == 1) s_busy1 = int'(oBusy);
      if (oPlot) begin
        if (s_plots == 0) begin s_first_x = int'(oX); s_first_y = int'(oY); end
        s_last_x = int'(oX); s_last_y = int'(oY);
        s_plots++;
        if (oColour != 3'd0) s_nonblack++;
        if (oX < 8'd144 && oY < 7'd100) frame[oX][oY] = oColour;
      end
      if (oDone) begin s_done_cnt++; s_done_cyc = cyc; end
      if (s_done_cnt > 0 && cyc > s_done_cyc && oBusy) s_busy_bad++;
      iStart = oDone;  // start during the DONE cycle must be ignored
      @(negedge clk);
    end
    iStart = 1'b0;
  endtask

  task automatic test_reset();
    iReset = 1'b0; iGameMode = 2'b10; iStart = 1'b0;
    #12;
    n_cmp++; if (oPlot !== 1'b0)   begin n_bad++; $display("FAIL reset_plot got %b want 0", oPlot); end
    n_cmp++; if (oBusy !== 1'b0)   begin n_bad++; $display("FAIL reset_busy got %b want 0", oBusy); end
    n_cmp++; if (oDone !== 1'b0)   begin n_bad++; $display("FAIL reset_done got %b want 0", oDone); end
    n_cmp++; if (oX !== 8'd0)      begin n_bad++; $display("FAIL reset_x got %0d want 0", oX); end
    n_cmp++; if (oY !== 7'd0)      begin n_bad++; $display("FAIL reset_y got %0d want 0", oY); end
    n_cmp++; if (oColour !== 3'd0) begin n_bad++; $display("FAIL reset_colour got %0d want 0", oColour); end
    n_cmp++; if (oCellAddr !== 6'd0) begin n_bad++; $display("FAIL reset_addr got %0d want 0", oCellAddr); end
    @(negedge clk); iReset = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_wrong_mode();
    int busy_seen;
    busy_seen = 0;
    iGameMode = 2'b01;
    pulse_start();
    for (int i = 0; i < 4; i++) begin
      if (oBusy) busy_seen++;
      @(negedge clk);
    end
    n_cmp++; if (busy_seen !== 0) begin n_bad++; $display("FAIL wrong_mode_start busy_cycles %0d want 0", busy_seen); end
    iGameMode = 2'b10;
  endtask

  task automatic test_blank_sweep();
    for (int i = 0; i < 40; i++) mem[i] = 7'h00;
    run_sweep(10330);
    n_cmp++; if (s_busy1 !== 1)      begin n_bad++; $display("FAIL blank_busy_c1 got %0d want 1", s_busy1); end
    n_cmp++; if (s_plots !== 10240)  begin n_bad++; $display("FAIL blank_plots got %0d want 10240", s_plots); end
    n_cmp++; if (s_nonblack !== 0)   begin n_bad++; $display("FAIL blank_colour nonblack %0d want 0", s_nonblack); end
    n_cmp++; if (s_first_x !== 16)   begin n_bad++; $display("FAIL blank_first_x got %0d want 16", s_first_x); end
    n_cmp++; if (s_first_y !== 20)   begin n_bad++; $display("FAIL blank_first_y got %0d want 20", s_first_y); end
    n_cmp++; if (s_last_x !== 143)   begin n_bad++; $display("FAIL blank_last_x got %0d want 143", s_last_x); end
    n_cmp++; if (s_last_y !== 99)    begin n_bad++; $display("FAIL blank_last_y got %0d want 99", s_last_y); end
    n_cmp++; if (s_done_cnt !== 1)   begin n_bad++; $display("FAIL blank_done_count got %0d want 1", s_done_cnt); end
    n_cmp++; if (s_done_cyc !== 10321) begin n_bad++; $display("FAIL blank_done_cycle got %0d want 10321", s_done_cyc); end
    n_cmp++; if (s_busy_bad !== 0)   begin n_bad++; $display("FAIL start_in_done busy_cycles %0d want 0", s_busy_bad); end
  endtask

  task automatic check_px(input string name, input int x, input int y, input int want);
    n_cmp++;
    if (int'(frame[x][y]) !== want) begin
      n_bad++; $display("FAIL %s (%0d,%0d) got %0d want %0d", name, x, y, frame[x][y], want);
    end
  endtask

  task automatic test_patterns();
    int bad_px, bx, by, bg, bw;
    for (int i = 0; i < 40; i++) mem[i] = 7'h00;
    mem[0] = 7'b1000101;
    mem[9] = 7'b1110111;
    mem[3] = 7'b1100111;
    run_sweep(10330);
    n_cmp++; if (s_plots !== 10240) begin n_bad++; $display("FAIL pat_plots got %0d want 10240", s_plots); end
    check_px("hidden_tl",  16, 20, 7);
    check_px("hidden_in",  17, 21, 7);
    check_px("hidden_br",  30, 34, 7);
    check_px("hidden_gapx", 31, 20, 0);
    check_px("hidden_gapy", 16, 35, 0);
    check_px("c9_bg",      32, 36, 1);
    check_px("c9_two_tl",  34, 39, 7);
    check_px("c9_two_r1",  33, 41, 1);
    check_px("c9_three_tl", 40, 39, 7);
    check_px("c9_three_r1", 44, 41, 7);
    check_px("c9_three_r1b", 40, 41, 1);
    check_px("c3_tens_bg", 66, 23, 1);
    check_px("c3_seven_r0", 72, 23, 7);
    check_px("c3_seven_r1", 72, 25, 1);
    check_px("c3_seven_r1c", 76, 25, 7);
    check_px("c3_seven_r4c", 76, 32, 7);
    check_px("c3_seven_r4a", 72, 32, 1);
    bad_px = 0; bx = -1; by = -1; bg = 0; bw = 0;
    for (int x = 16; x < 144; x++)
      for (int y = 20; y < 100; y++)
        if (int'(frame[x][y]) != exp_colour(x, y)) begin
          if (bad_px == 0) begin bx = x; by = y; bg = int'(frame[x][y]); bw = exp_colour(x, y); end
          bad_px++;
        end
    n_cmp++;
    if (bad_px !== 0) begin
      n_bad++; $display("FAIL pat_frame %0d bad pixels, first (%0d,%0d) got %0d want %0d", bad_px, bx, by, bg, bw);
    end
  endtask

  task automatic test_abort();
    int late_done, late_busy;
    late_done = 0; late_busy = 0;
    pulse_start();
    for (int cyc = 1; cyc <= 530; cyc++) begin
      iStart = (cyc == 100);
      if (cyc == 500) begin
        n_cmp++; if (oPlot !== 1'b1) begin n_bad++; $display("FAIL abort_pre_plot got %b want 1", oPlot); end
        n_cmp++; if (oX !== 8'd47)   begin n_bad++; $display("FAIL abort_pre_x got %0d want 47", oX); end
        n_cmp++; if (oY !== 7'd34)   begin n_bad++; $display("FAIL abort_pre_y got %0d want 34", oY); end
        iGameMode = 2'b01;
      end
      if (cyc == 501) begin
        n_cmp++; if (oPlot !== 1'b0) begin n_bad++; $display("FAIL abort_plot got %b want 0", oPlot); end
        n_cmp++; if (oBusy !== 1'b0) begin n_bad++; $display("FAIL abort_busy got %b want 0", oBusy); end
      end
      if (cyc >= 501) begin
        if (oDone) late_done++;
        if (oBusy) late_busy++;
      end
      @(negedge clk);
    end
    iStart = 1'b0;
    n_cmp++; if (late_done !== 0) begin n_bad++; $display("FAIL abort_no_done got %0d pulses want 0", late_done); end
    n_cmp++; if (late_busy !== 0) begin n_bad++; $display("FAIL abort_stays_idle busy_cycles %0d want 0", late_busy); end
    iGameMode = 2'b10;
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    pulse_start();
    for (int cyc = 1; cyc < 50; cyc++) @(negedge clk);
    #2 iReset = 1'b0;
    #1;
    n_cmp++; if (oPlot !== 1'b0) begin n_bad++; $display("FAIL midreset_plot got %b want 0", oPlot); end
    n_cmp++; if (oBusy !== 1'b0) begin n_bad++; $display("FAIL midreset_busy got %b want 0", oBusy); end
    @(negedge clk); iReset = 1'b1;
    @(negedge clk);
    pulse_start();
    n_cmp++; if (oBusy !== 1'b1)     begin n_bad++; $display("FAIL restart_busy got %b want 1", oBusy); end
    n_cmp++; if (oCellAddr !== 6'd0) begin n_bad++; $display("FAIL restart_addr got %0d want 0", oCellAddr); end
    @(negedge clk); @(negedge clk);
    n_cmp++; if (oPlot !== 1'b1) begin n_bad++; $display("FAIL restart_plot got %b want 1", oPlot); end
    n_cmp++; if (oX !== 8'd16)   begin n_bad++; $display("FAIL restart_x got %0d want 16", oX); end
    n_cmp++; if (oY !== 7'd20)   begin n_bad++; $display("FAIL restart_y got %0d want 20", oY); end
    iReset = 1'b0;
    @(negedge clk); iReset = 1'b1;
  endtask

  initial begin
    font[0] = 15'b111_101_101_101_111;
    font[1] = 15'b010_110_010_010_111;
    font[2] = 15'b111_001_111_100_111;
    font[3] = 15'b111_001_111_001_111;
    font[4] = 15'b101_101_111_001_001;
    font[5] = 15'b111_100_111_001_111;
    font[6] = 15'b111_100_111_101_111;
    font[7] = 15'b111_001_001_001_001;
    font[8] = 15'b111_101_111_101_111;
    font[9] = 15'b111_101_111_001_111;
    for (int i = 0; i < 40; i++) mem[i] = 7'h00;
    test_reset();
    test_wrong_mode();
    test_blank_sweep();
    test_patterns();
    test_abort();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
